// File: rtl/receiver_uart.sv
// UART receiver: 2-FF synchroniser, 16x-oversampled start/data/parity/stop
// framing with even parity, plus the baud tick generator it owns.

// Sample-tick generator: one-clk tick every (clk / (16 * baud)) cycles,
// divisors for a 50 MHz system clock.
module baud_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] i_baud_select,
  output logic       o_tick
);

  logic [13:0] w_limit;
  logic [13:0] r_cnt;
  logic        r_tick;

  // Divisor lookup for the selected baud rate.
  // NOTE: every path assigns w_limit up front, so no latch can be inferred.
  always_comb begin
    w_limit = 14'd27;
    case (i_baud_select)
      3'b000:  w_limit = 14'd10417; //    300 baud
      3'b001:  w_limit = 14'd2604;  //   1200 baud
      3'b010:  w_limit = 14'd651;   //   4800 baud
      3'b011:  w_limit = 14'd326;   //   9600 baud
      3'b100:  w_limit = 14'd163;   //  19200 baud
      3'b101:  w_limit = 14'd81;    //  38400 baud
      3'b110:  w_limit = 14'd54;    //  57600 baud
      default: w_limit = 14'd27;    // 115200 baud
    endcase
  end

  // Free-running divider; >= keeps it bounded if the rate code shrinks mid-count.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_tick <= 1'b0;
    end else if (r_cnt >= w_limit - 14'd1) begin
      r_cnt  <= '0;
      r_tick <= 1'b1;
    end else begin
      r_cnt  <= r_cnt + 14'd1;
      r_tick <= 1'b0;
    end
  end

  assign o_tick = r_tick;

endmodule

module receiver_uart #(
  parameter int DATA_BITS = 8,
  parameter int OVS       = 16,
  parameter int MID       = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [2:0]           baud_select,
  input  logic                 RX_EN,
  input  logic                 RxD,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_PERROR,
  output logic                 Rx_FERROR,
  output logic                 Rx_VALID
);

  localparam int CW = $clog2(OVS);
  localparam int IW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CNT_MID  = CW'(MID);
  localparam logic [CW-1:0] CNT_LAST = CW'(OVS - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_DONE
  } state_t;

  state_t               r_state, w_state_n;
  logic [CW-1:0]        r_cnt, w_cnt_n;
  logic [IW-1:0]        r_idx, w_idx_n;
  logic [DATA_BITS-1:0] r_shift, w_shift_n;
  logic                 r_perr, w_perr_n;
  logic                 r_ferr, w_ferr_n;
  logic                 r_armed, w_armed_n;
  logic                 w_deliver;
  logic [1:0]           r_sync;
  logic                 w_rxd;
  logic                 w_tick;
  logic [DATA_BITS-1:0] r_rx_data;
  logic                 r_rx_perr, r_rx_ferr, r_rx_valid;

  baud_controller u_baud (
    .clk           (clk),
    .reset         (reset),
    .i_baud_select (baud_select),
    .o_tick        (w_tick)
  );

  // Two-flop synchroniser for the asynchronous line; idles high.
  always_ff @(posedge clk) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], RxD};
  end

  assign w_rxd = r_sync[1];

  // FSM state and frame-assembly registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      r_armed <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_cnt   <= w_cnt_n;
      r_idx   <= w_idx_n;
      r_shift <= w_shift_n;
      r_perr  <= w_perr_n;
      r_ferr  <= w_ferr_n;
      r_armed <= w_armed_n;
    end
  end

  // Next-state logic; counters only move on tick cycles, DONE needs no tick.
  always_comb begin
    w_state_n = r_state;
    w_cnt_n   = r_cnt;
    w_idx_n   = r_idx;
    w_shift_n = r_shift;
    w_perr_n  = r_perr;
    w_ferr_n  = r_ferr;
    w_armed_n = r_armed;
    w_deliver = 1'b0;
    if (!RX_EN) begin
      // Drop any partial frame; wait for an idle line before re-arming.
      w_state_n = S_IDLE;
      w_armed_n = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (w_tick) begin
          if (w_rxd) begin
            w_armed_n = 1'b1;
          end else if (r_armed) begin
            w_state_n = S_START;
            w_cnt_n   = '0;
          end
        end
        S_START: if (w_tick) begin
          if (r_cnt == CNT_MID) begin
            if (w_rxd) begin
              w_state_n = S_IDLE;        // too short to be a start bit
            end else begin
              w_state_n = S_DATA;
              w_cnt_n   = '0;
              w_idx_n   = '0;
            end
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
        S_DATA: if (w_tick) begin
          w_cnt_n = r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_shift_n = {w_rxd, r_shift[DATA_BITS-1:1]};
            w_idx_n   = r_idx + 1'b1;
            if (r_idx == IDX_LAST) w_state_n = S_PARITY;
          end
        end
        S_PARITY: if (w_tick) begin
          w_cnt_n = r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_perr_n  = w_rxd ^ (^r_shift);
            w_state_n = S_STOP;
          end
        end
        S_STOP: if (w_tick) begin
          w_cnt_n = r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_ferr_n  = ~w_rxd;
            w_state_n = S_DONE;
          end
        end
        S_DONE: begin
          w_deliver = 1'b1;
          w_armed_n = ~r_ferr;           // after a bad stop, wait for line high
          w_state_n = S_IDLE;
        end
        default: w_state_n = S_IDLE;
      endcase
    end
  end

  // Host-facing output registers; data and flags hold between frames.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_data  <= '0;
      r_rx_perr  <= 1'b0;
      r_rx_ferr  <= 1'b0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= w_deliver;
      if (w_deliver) begin
        r_rx_data <= r_shift;
        r_rx_perr <= r_perr;
        r_rx_ferr <= r_ferr;
      end
    end
  end

  assign Rx_DATA   = r_rx_data;
  assign Rx_PERROR = r_rx_perr;
  assign Rx_FERROR = r_rx_ferr;
  assign Rx_VALID  = r_rx_valid;

endmodule

// File: tb/tb_receiver_uart.sv
// Bench for receiver_uart: bit-level line driver, queue of expected frames,
// and a per-cycle compare process against held/pulsed outputs.
module tb_receiver_uart;

  localparam int TICK_CLKS = 27;             // 50 MHz / (16 * 115200)
  localparam int BIT_CLKS  = 16 * TICK_CLKS;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       fe;
  } frame_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] baud_select;
  logic       RX_EN;
  logic       RxD;
  logic [7:0] Rx_DATA;
  logic       Rx_PERROR;
  logic       Rx_FERROR;
  logic       Rx_VALID;

  frame_t     exp_q[$];
  logic [7:0] m_data = '0;
  logic       m_pe = 1'b0;
  logic       m_fe = 1'b0;
  logic       prev_valid = 1'b0;
  int         n_valid = 0;
  int         n_checks = 0;
  int         n_errors = 0;

  receiver_uart dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .RX_EN       (RX_EN),
    .RxD         (RxD),
    .Rx_DATA     (Rx_DATA),
    .Rx_PERROR   (Rx_PERROR),
    .Rx_FERROR   (Rx_FERROR),
    .Rx_VALID    (Rx_VALID)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every cycle: outputs must equal the model's last delivered frame; a
  // Rx_VALID pulse must be single-cycle and consume one pending frame.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      m_data = '0;
      m_pe   = 1'b0;
      m_fe   = 1'b0;
      exp_q.delete();
      check("valid_in_reset", Rx_VALID, 0);
    end else if (Rx_VALID) begin
      n_valid++;
      check("valid_width", prev_valid, 0);
      check("frame_pending", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        m_data = exp_q[0].data;
        m_pe   = exp_q[0].pe;
        m_fe   = exp_q[0].fe;
        void'(exp_q.pop_front());
      end
    end
    check("rx_data", Rx_DATA, m_data);
    check("rx_perror", Rx_PERROR, m_pe);
    check("rx_ferror", Rx_FERROR, m_fe);
    prev_valid = Rx_VALID;
  end

  task automatic idle_bits(input int n);
    RxD = 1'b1;
    repeat (n * BIT_CLKS) @(negedge clk);
  endtask

  // Drive one 11-bit frame. abort_at >= 0 asserts reset (or drops RX_EN)
  // at that bit index and releases it once the frame has ended.
  task automatic send_frame(input logic [7:0] data, input bit bad_par, input bit stop,
                            input int abort_at, input bit abort_by_reset);
    logic [10:0] bits;
    int v0;
    bits = {stop, (^data) ^ bad_par, data, 1'b0};
    v0 = n_valid;
    if (abort_at < 0) exp_q.push_back('{data: data, pe: bad_par, fe: ~stop});
    for (int i = 0; i < 11; i++) begin
      if (i == abort_at) begin
        if (abort_by_reset) reset = 1'b1;
        else                RX_EN = 1'b0;
      end
      RxD = bits[i];
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (abort_at >= 0) begin
      reset = 1'b0;
      RX_EN = 1'b1;
      check("aborted_no_valid", n_valid - v0, 0);
    end else begin
      check("frame_delivered", n_valid - v0, 1);
      check("queue_drained", exp_q.size(), 0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0;
    reset       = 1'b1;
    RX_EN       = 1'b1;
    RxD         = 1'b1;
    baud_select = 3'b111;
    repeat (5) @(negedge clk);
    check("reset_data", Rx_DATA, 8'h00);
    check("reset_valid", Rx_VALID, 0);
    reset = 1'b0;
    idle_bits(2);

    // Clean frame.
    send_frame(8'hA5, 1'b0, 1'b1, -1, 1'b0);
    check("t1_data", Rx_DATA, 8'hA5);
    check("t1_perr", Rx_PERROR, 0);
    check("t1_ferr", Rx_FERROR, 0);

    // Wrong parity bit.
    send_frame(8'h55, 1'b1, 1'b1, -1, 1'b0);
    check("t2_data", Rx_DATA, 8'h55);
    check("t2_perr", Rx_PERROR, 1);
    check("t2_ferr", Rx_FERROR, 0);

    // Stop bit low, line high again, then a clean frame.
    send_frame(8'h0F, 1'b0, 1'b0, -1, 1'b0);
    check("t3_data", Rx_DATA, 8'h0F);
    check("t3_ferr", Rx_FERROR, 1);
    idle_bits(1);
    send_frame(8'h81, 1'b0, 1'b1, -1, 1'b0);
    check("t3b_data", Rx_DATA, 8'h81);
    check("t3b_ferr", Rx_FERROR, 0);

    // Short low glitch must not start a frame.
    v0 = n_valid;
    RxD = 1'b0;
    repeat (4 * TICK_CLKS) @(negedge clk);
    idle_bits(2);
    check("glitch_no_valid", n_valid - v0, 0);

    // Back-to-back frames with no idle gap, as a transmitter emits them.
    send_frame(8'h3C, 1'b0, 1'b1, -1, 1'b0);
    check("t5a_data", Rx_DATA, 8'h3C);
    send_frame(8'hC3, 1'b0, 1'b1, -1, 1'b0);
    check("t5b_data", Rx_DATA, 8'hC3);
    check("t5b_perr", Rx_PERROR, 0);
    idle_bits(1);

    // Reset during data bits: outputs cleared, frame dropped, next frame clean.
    send_frame(8'h77, 1'b0, 1'b1, 3, 1'b1);
    check("t6_reset_data", Rx_DATA, 8'h00);
    idle_bits(1);
    send_frame(8'h12, 1'b0, 1'b1, -1, 1'b0);
    check("t6_data", Rx_DATA, 8'h12);

    // RX_EN dropped during data bits: outputs hold, frame dropped.
    idle_bits(1);
    send_frame(8'h77, 1'b0, 1'b1, 4, 1'b0);
    check("t6_en_hold", Rx_DATA, 8'h12);
    idle_bits(1);

    // Randomised frames with occasional parity and framing errors.
    for (int k = 0; k < 5; k++) begin
      logic [7:0] d;
      bit bp, st;
      d  = 8'($urandom);
      bp = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 4) != 0);
      send_frame(d, bp, st, -1, 1'b0);
      if (!st) idle_bits(1);
      RxD = 1'b1;
      repeat ($urandom_range(0, 200)) @(negedge clk);
    end

    repeat (10) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
